// File: rtl/alu_div_pkg.sv
// Purpose: shared types and constants for the ALU signed divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_div_pkg;

    // Operand / result width of the ALU divider.
    localparam int DIV_WIDTH = 16;

    // Iteration counter width: must be able to hold the value DIV_WIDTH.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/divider_unsigned.sv
// Purpose: radix-2 restoring divider core on unsigned magnitudes.
// Latency: WIDTH cycles after load; last_iter is high during the final iteration.
// Backpressure: none; a load restarts the core at any time.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load            capture dividend/divisor and restart the iteration
//   dividend        unsigned dividend magnitude
//   divisor         unsigned divisor magnitude
//   quotient        unsigned quotient (valid after the last iteration)
//   remainder       unsigned remainder (valid after the last iteration)
//   last_iter       high in the cycle whose edge completes iteration WIDTH
module divider_unsigned
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last_iter
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // The shifted partial remainder and the trial difference carry one extra
    // bit so the borrow of the trial subtraction is visible in the MSB. The
    // stored remainder is always below the divisor, so it fits in WIDTH bits.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    assign rem_sh    = {rem, dvd[WIDTH-1]};
    assign trial     = rem_sh - {1'b0, dsr};
    assign q_bit     = ~trial[WIDTH];
    assign last_iter = run && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= '0;
            dvd <= '0;
            dsr <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            rem <= '0;
            dvd <= dividend;
            dsr <= divisor;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            // Quotient bits shift into the vacated low end of the dividend.
            rem <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], q_bit};
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                run <= 1'b0;
            end
        end
    end

    assign quotient  = dvd;
    assign remainder = rem;

endmodule

// File: rtl/signed_divider.sv
// Purpose: sequential signed divider (truncating quotient, remainder follows dividend) with ALU flags.
// Latency: done pulses 18 cycles after start (2 cycles when b==0).
// Backpressure: start is ignored while busy; results hold until the next completion.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle request, sampled only when idle
//   a, b            signed dividend and divisor
//   quotient        signed quotient, truncated toward zero
//   remainder       signed remainder, sign follows the dividend
//   busy            operation in flight
//   done            one-cycle pulse when results are valid
//   div_zero        last operation had b==0
//   Z, N, C, V      zero / negative / carry (always 0) / overflow-or-div-by-zero
module signed_divider
    import alu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       next_state;
    logic             load;
    logic             fix;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] uq;
    logic [WIDTH-1:0] ur;
    logic             last_iter;

    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic             ovf;
    logic [WIDTH-1:0] a_hold;

    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    // Two's-complement magnitudes; the most-negative value maps to
    // 2^(WIDTH-1), which is correct when read as unsigned.
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    divider_unsigned #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (uq),
        .remainder (ur),
        .last_iter (last_iter)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        fix        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (b == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                fix        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Operand attributes captured at start so a and b may change afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            a_hold <= '0;
        end else if (load) begin
            sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r <= a[WIDTH-1];
            dz     <= (b == '0);
            ovf    <= (a == MOST_NEG) && (b == '1);
            a_hold <= a;
        end
    end

    // Sign correction. In the overflow case sign_q is 0 and the magnitude
    // quotient 2^(WIDTH-1) passes straight through as the most-negative value.
    always_comb begin
        q_res = sign_q ? (~uq + WIDTH'(1)) : uq;
        r_res = sign_r ? (~ur + WIDTH'(1)) : ur;
        if (dz) begin
            q_res = DIV_ZERO_QUOT;
            r_res = a_hold;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            V         <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= fix;
            if (fix) begin
                quotient  <= q_res;
                remainder <= r_res;
                div_zero  <= dz;
                Z         <= (q_res == '0);
                N         <= q_res[WIDTH-1];
                V         <= dz | ovf;
            end
        end
    end

    assign C = 1'b0;

endmodule

// File: tb/tb_signed_divider.sv
// Purpose: directed self-checking bench for signed_divider.
// Latency: n/a.
// Backpressure: n/a.
module tb_signed_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        Z;
    logic        N;
    logic        C;
    logic        V;

    int n_cmp = 0;
    int n_bad = 0;

    signed_divider #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .Z         (Z),
        .N         (N),
        .C         (C),
        .V         (V)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a point just after a rising edge and follow it
    // until done. lat is the number of rising edges from the one that samples
    // start up to and including the one after which done is seen (-1 if never).
    // extra_at: pulse start again (with different operands) after that edge.
    // rst_at:   assert reset after that edge and abandon the operation.
    task automatic do_op(input logic [15:0] aa, input logic [15:0] bb,
                         input int extra_at, input int rst_at, output int lat);
        a     = aa;
        b     = bb;
        start = 1'b1;
        lat   = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 1) chk_eq("busy_after_start", {31'd0, busy}, 32'd1);
            if (i == rst_at) begin
                rst = 1'b0;
                break;
            end
            if (done) begin
                lat = i;
                chk_eq("busy_at_done", {31'd0, busy}, 32'd0);
                break;
            end
            if (i == extra_at) begin
                a     = 16'd77;
                b     = 16'd1;
                start = 1'b1;
            end
        end
    endtask

    // Flags packed as {div_zero, Z, N, C, V}.
    task automatic run_chk(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                           input int extra_at, input logic [15:0] eq, input logic [15:0] er,
                           input logic [4:0] ef, input int elat);
        int lat;
        do_op(aa, bb, extra_at, 0, lat);
        chk_eq({tag, "_latency"}, lat, elat);
        chk_eq({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
        chk_eq({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
        chk_eq({tag, "_flags"}, {27'd0, div_zero, Z, N, C, V}, {27'd0, ef});
    endtask

    initial begin
        int lat;
        int seen;

        // Reset state while rst is held low.
        #12;
        chk_eq("reset_quotient", {16'd0, quotient}, 32'd0);
        chk_eq("reset_remainder", {16'd0, remainder}, 32'd0);
        chk_eq("reset_busy", {31'd0, busy}, 32'd0);
        chk_eq("reset_done", {31'd0, done}, 32'd0);
        chk_eq("reset_flags", {27'd0, div_zero, Z, N, C, V}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Consecutive operations: each new start lands in the done cycle of
        // the previous one, so an 18-cycle latency also shows it was accepted.
        run_chk("p100_d7",   16'd100,   16'd7,     0, 16'h000E, 16'h0002, 5'b00000, 18);
        run_chk("m100_d7",   16'hFF9C,  16'd7,     0, 16'hFFF2, 16'hFFFE, 5'b00100, 18);
        run_chk("p100_dm7",  16'd100,   16'hFFF9,  0, 16'hFFF2, 16'h0002, 5'b00100, 18);
        run_chk("p5_d0",     16'd5,     16'd0,     0, 16'hFFFF, 16'h0005, 5'b10101, 2);
        run_chk("min_dm1",   16'h8000,  16'hFFFF,  0, 16'h8000, 16'h0000, 5'b00101, 18);
        run_chk("min_d2",    16'h8000,  16'd2,     0, 16'hC000, 16'h0000, 5'b00100, 18);
        run_chk("p3_d5_bsy", 16'd3,     16'd5,     5, 16'h0000, 16'h0003, 5'b01000, 18);

        // Abort 1000/3 with reset after the 8th edge.
        do_op(16'd1000, 16'd3, 0, 8, lat);
        #1;
        chk_eq("abort_quotient", {16'd0, quotient}, 32'd0);
        chk_eq("abort_remainder", {16'd0, remainder}, 32'd0);
        chk_eq("abort_busy", {31'd0, busy}, 32'd0);
        chk_eq("abort_done", {31'd0, done}, 32'd0);
        chk_eq("abort_flags", {27'd0, div_zero, Z, N, C, V}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk_eq("abort_no_done", seen, 32'd0);

        run_chk("p1000_d3", 16'd1000, 16'd3, 0, 16'd333, 16'd1, 5'b00000, 18);

        // Results hold after the done pulse.
        repeat (3) @(posedge clk);
        #1;
        chk_eq("hold_quotient", {16'd0, quotient}, 32'd333);
        chk_eq("hold_remainder", {16'd0, remainder}, 32'd1);
        chk_eq("hold_done", {31'd0, done}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
